fpu_adder_arbiter: RTL and testbench
====================================

Name: fpu_adder_arbiter

Overview:
- Shares one multi-cycle FP32 adder among NUM_REQ requesters (rasterizer and vertex-transform clients).
- Arbitrates round-robin and optionally negates operand B to turn an add into a subtract.
- Latches the winning operands, issues one exec strobe, waits for the adder's done strobe, then returns the result to the granted requester.
- A watchdog recovers the arbiter if the adder never completes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, cycles to wait for adder done before a forced error completion; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset_ni  in  1  synchronous reset, active-low.
- req_valid_i  in  NUM_REQ  per-requester request.
- req_sub_i  in  NUM_REQ  1 = compute a-b (flip b[31] at latch).
- req_a_i  in  NUM_REQ x 32  operand A per requester.
- req_b_i  in  NUM_REQ x 32  operand B per requester.
- req_ready_o  out  NUM_REQ  one-hot grant pulse; operands accepted this cycle.
- rsp_valid_o  out  NUM_REQ  one-hot result pulse to the granted requester.
- rsp_value_o  out  32  result, valid while any rsp_valid_o bit is high.
- rsp_err_o  out  1  high with rsp_valid_o when the watchdog fired.
- busy_o  out  1  high from grant until the response cycle inclusive.
- adder_reset_o  out  1  = !reset_ni, combinational; the adder resets with the arbiter.
- adder_a_o  out  32  latched operand A to the adder.
- adder_b_o  out  32  latched operand B to the adder.
- adder_exec_o  out  1  one-cycle exec strobe.
- adder_z_i  in  32  adder result.
- adder_done_i  in  1  adder done strobe (one-cycle pulse).

Behaviour:
- Reset values (reset_ni=0 at clk edge):
  - state=IDLE, rr_ptr=0, timer=0.
  - req_ready_o=0, rsp_valid_o=0, rsp_err_o=0, busy_o=0, adder_exec_o=0.
  - adder_a_o=0, adder_b_o=0, rsp_value_o=0.
- Arbitration:
  - Evaluated only in IDLE.
  - Winner is the first asserted req_valid_i starting at index rr_ptr, wrapping modulo NUM_REQ.
  - After a grant to index g, rr_ptr <= (g+1) mod NUM_REQ.
  - No grant when no request is pending; rr_ptr is unchanged.
- Requester handshake:
  - A requester holds req_valid_i and its operands stable until it sees req_ready_o.
  - req_ready_o is a registered one-cycle pulse, asserted in the cycle after the arbitration decision.
  - The requester may drop or change its request the cycle after req_ready_o.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  - IDLE:
    - On a winner g: latch adder_a_o=req_a_i[g].
    - Latch adder_b_o=req_b_i[g] with bit31 XOR req_sub_i[g].
    - Record the one-hot grant index, pulse req_ready_o[g] next cycle, go to ISSUE.
  - ISSUE:
    - adder_exec_o=1 for exactly this one cycle.
    - timer<=0, go to WAIT.
  - WAIT:
    - If adder_done_i=1: latch rsp_value_o=adder_z_i, rsp_err_o=0, go to RESP.
    - Otherwise, if TIMEOUT!=0 and timer==TIMEOUT-1: rsp_value_o=32'hFFC00000 (quiet NaN), rsp_err_o=1, go to RESP.
    - Otherwise timer++.
  - RESP:
    - rsp_valid_o[g]=1 for one cycle, then go to IDLE.
    - A new grant decision may be made in the next IDLE cycle.
- adder_a_o and adder_b_o hold stable from ISSUE through RESP; the adder samples them after the exec strobe.
- Latency:
  - Grant to exec is 1 cycle.
  - Done to rsp_valid is 1 cycle.
  - Back-to-back throughput is adder latency + 3 cycles.
- Boundary conditions:
  - adder_done_i outside WAIT is ignored, e.g. a late done after a timeout.
  - A request arriving during a transaction waits; there is no preemption.
  - A requester dropping req_valid_i before its grant withdraws cleanly.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Reset mid-transaction aborts it: no rsp_valid_o is issued, and the adder is reset in the same cycle via adder_reset_o.
- Width rules:
  - timer width is $clog2(TIMEOUT+1).
  - The grant index is stored one-hot (NUM_REQ bits) and as binary ($clog2(NUM_REQ)).

Decomposition:
- fpu_pkg holds:
  - the arbiter state enum;
  - FP32_QNAN = 32'hFFC00000;
  - the fp32_t typedef (logic [31:0]);
  - a sign-flip function used for subtraction.
- Sub-module rr_arbiter (parameterised NUM_REQ): combinational round-robin priority pick given the request vector and pointer, returning a one-hot grant plus a valid flag.
- The FSM, operand latch and watchdog stay in fpu_adder_arbiter.

Test Plan:
1. Single request from req 0 with a=0x3F800000, b=0x40000000, sub=0, adder model attached -> req_ready_o=0001 one cycle, one adder_exec_o pulse, rsp_valid_o=0001 with rsp_value_o=0x40400000, rsp_err_o=0.
2. Request from req 2 with a=0x40400000, b=0x3F800000, sub=1 -> adder_b_o=0xBF800000, rsp_value_o=0x40000000 on rsp_valid_o=0100.
3. All four req_valid_i held high for 8 transactions after reset -> grant order 0,1,2,3,0,1,2,3; exactly one exec per grant; no overlap of busy_o cycles.
4. a=0x7FC00000, b=0x3F800000 -> rsp_value_o=0xFFC00000 passed through from the adder, rsp_err_o=0.
5. Stub adder that never asserts done, TIMEOUT=64 -> rsp_valid_o exactly 64 cycles after the exec pulse, rsp_value_o=0xFFC00000, rsp_err_o=1; a late done pulse afterwards is ignored.
6. reset_ni=0 for one cycle while in WAIT -> adder_reset_o=1 in the same cycle, no rsp_valid_o, rr_ptr=0, next request from req 3 is granted normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared types and constants for the shared FP32 adder arbiter.
//   fp32_t         : raw IEEE-754 single-precision bit pattern
//   arb_state_e    : arbiter transaction state
//   FP32_QNAN      : canonical quiet NaN returned on a watchdog completion
//   fp32_flip_sign : negates an operand so the adder computes a-b
// ---------------------------------------------------------------------------
package fpu_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  localparam fp32_t FP32_QNAN = 32'hFFC00000;

  // Flipping only the sign bit negates any FP32 value, including zeros,
  // infinities and NaNs, so a subtract is an add with a negated B.
  function automatic fp32_t fp32_flip_sign(input fp32_t v, input logic flip);
    return {v[31] ^ flip, v[30:0]};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the winner is the first asserted request
// found when scanning upward from ptr_i, wrapping modulo NUM_REQ.
// Ports:
//   req_i   [NUM_REQ]         request vector
//   ptr_i   [$clog2(NUM_REQ)] index with highest priority this cycle
//   grant_o [NUM_REQ]         one-hot winner (all zero when nothing pending)
//   valid_o                   a winner exists
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       valid_o
);

  localparam int IW = $clog2(NUM_REQ);

  // Walk the requesters in priority order starting at the pointer; the
  // first one found claims the grant and blocks every later candidate.
  always_comb begin
    int            sum;
    logic [IW-1:0] idx;
    grant_o = '0;
    valid_o = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr_i) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IW'(sum);
      if (!valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_adder_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_adder_arbiter
// Shares one multi-cycle FP32 adder between NUM_REQ clients. A round-robin
// winner's operands are latched (B optionally negated for a subtract), one
// exec strobe is sent to the adder, and the result goes back to the winner
// on a one-cycle response pulse. A watchdog completes the transaction with a
// quiet NaN and an error flag if the adder never signals done.
// Ports:
//   clk, reset_ni                 clock, synchronous active-low reset
//   req_valid_i/req_sub_i         per-requester request and subtract select
//   req_a_i/req_b_i               per-requester operands
//   req_ready_o                   one-hot grant pulse (operands accepted)
//   rsp_valid_o                   one-hot response pulse to the winner
//   rsp_value_o, rsp_err_o        result and watchdog error flag
//   busy_o                        grant through response cycle inclusive
//   adder_reset_o                 adder reset, follows the arbiter reset
//   adder_a_o/adder_b_o           latched operands to the adder
//   adder_exec_o                  one-cycle start strobe to the adder
//   adder_z_i/adder_done_i        adder result and done strobe
// ---------------------------------------------------------------------------
module fpu_adder_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ-1:0]       req_sub_i,
  input  logic [NUM_REQ-1:0][31:0] req_a_i,
  input  logic [NUM_REQ-1:0][31:0] req_b_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [31:0]              rsp_value_o,
  output logic                     rsp_err_o,
  output logic                     busy_o,
  output logic                     adder_reset_o,
  output logic [31:0]              adder_a_o,
  output logic [31:0]              adder_b_o,
  output logic                     adder_exec_o,
  input  logic [31:0]              adder_z_i,
  input  logic                     adder_done_i
);

  localparam int IW = $clog2(NUM_REQ);
  // A disabled watchdog still gets a 1-bit timer so no zero-width vector
  // is ever declared.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
  logic [IW-1:0]      grant_idx_q, grant_idx_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  fp32_t              a_q, a_d;
  fp32_t              b_q, b_d;
  fp32_t              value_q, value_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_valid;
  logic [IW-1:0]      arb_idx;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req_i  (req_valid_i),
    .ptr_i  (rr_ptr_q),
    .grant_o(arb_grant),
    .valid_o(arb_valid)
  );

  // Binary form of the one-hot winner, used to index the operand buses.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) arb_idx = IW'(i);
    end
  end

  // State register. Reset clears everything, so a transaction caught
  // mid-flight is simply dropped without a response.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      timer_q     <= '0;
      grant_oh_q  <= '0;
      grant_idx_q <= '0;
      ready_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      value_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      timer_q     <= timer_d;
      grant_oh_q  <= grant_oh_d;
      grant_idx_q <= grant_idx_d;
      ready_q     <= ready_d;
      a_q         <= a_d;
      b_q         <= b_d;
      value_q     <= value_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic. The pointer advances in ISSUE from the stored
  // binary grant index; arbitration only looks at it in IDLE, so this is
  // equivalent to advancing it at grant time.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    grant_oh_d  = grant_oh_q;
    grant_idx_d = grant_idx_q;
    ready_d     = '0;
    a_d         = a_q;
    b_d         = b_q;
    value_d     = value_q;
    err_d       = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          a_d         = req_a_i[arb_idx];
          b_d         = fp32_flip_sign(req_b_i[arb_idx], req_sub_i[arb_idx]);
          grant_oh_d  = arb_grant;
          grant_idx_d = arb_idx;
          ready_d     = arb_grant;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IW'(1);
        timer_d  = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (adder_done_i) begin
          value_d = adder_z_i;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (TIMEOUT != 0 && timer_q == TIMER_LAST) begin
          value_d = FP32_QNAN;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are decoded from the state so each lasts exactly one cycle.
  assign req_ready_o   = ready_q;
  assign adder_exec_o  = (state_q == ST_ISSUE);
  assign rsp_valid_o   = (state_q == ST_RESP) ? grant_oh_q : '0;
  assign busy_o        = (state_q != ST_IDLE);
  assign rsp_value_o   = value_q;
  assign rsp_err_o     = err_q;
  assign adder_a_o     = a_q;
  assign adder_b_o     = b_q;
  assign adder_reset_o = !reset_ni;

endmodule

// File: tb/tb_fpu_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_adder_arbiter
// Drives randomized and directed request rounds into fpu_adder_arbiter with
// a behavioural adder attached. Each round predicts the grant order from a
// round-robin pointer model and pushes expected transactions into a queue;
// an independent monitor pops and compares on every grant, exec and
// response it observes.
// ---------------------------------------------------------------------------
module tb_fpu_adder_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] QNAN = 32'hFFC00000;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] value;
    logic        err;
    int          lat;
  } txn_t;

  logic                     clk;
  logic                     reset_ni;
  logic [NUM_REQ-1:0]       reqValid;
  logic [NUM_REQ-1:0]       reqSub;
  logic [NUM_REQ-1:0][31:0] reqA;
  logic [NUM_REQ-1:0][31:0] reqB;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0]       rsp_valid_o;
  logic [31:0]              rsp_value_o;
  logic                     rsp_err_o;
  logic                     busy_o;
  logic                     adder_reset_o;
  logic [31:0]              adder_a_o;
  logic [31:0]              adder_b_o;
  logic                     adder_exec_o;
  logic [31:0]              adderZ;
  logic                     adderDone;

  int compared   = 0;
  int mismatched = 0;
  int cycleCount = 0;

  txn_t expQ[$];
  int   modelPtr = 0;
  int   rspCount = 0;
  int   resetCount = 0;
  int   lateDoneCount = 0;
  int   adderLatency = 2;
  bit   adderMute = 0;
  bit   anyReady = 0;

  logic [31:0]        dirA [NUM_REQ];
  logic [31:0]        dirB [NUM_REQ];
  logic               dirSub [NUM_REQ];
  logic [31:0]        lastRspValue;
  logic [NUM_REQ-1:0] lastRspMask;
  logic               lastRspErr;
  logic [31:0]        lastAdderB;
  int                 lastLatency;

  fpu_adder_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset_ni     (reset_ni),
    .req_valid_i  (reqValid),
    .req_sub_i    (reqSub),
    .req_a_i      (reqA),
    .req_b_i      (reqB),
    .req_ready_o  (req_ready_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_value_o  (rsp_value_o),
    .rsp_err_o    (rsp_err_o),
    .busy_o       (busy_o),
    .adder_reset_o(adder_reset_o),
    .adder_a_o    (adder_a_o),
    .adder_b_o    (adder_b_o),
    .adder_exec_o (adder_exec_o),
    .adder_z_i    (adderZ),
    .adder_done_i (adderDone)
  );

  // Free-running clock and a cycle counter used for latency measurement.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Operands are small integers encoded as FP32, so sums are exact and the
  // reference adder needs only integer arithmetic.
  function automatic int fp32ToInt(input logic [31:0] v);
    int          e;
    int unsigned mag;
    e = int'(v[30:23]);
    if (e < 127) return 0;
    mag = {8'd0, 1'b1, v[22:0]} >> (150 - e);
    return v[31] ? -int'(mag) : int'(mag);
  endfunction

  function automatic logic [31:0] intToFp32(input int x);
    int          mag;
    int          p;
    logic [31:0] frac;
    logic [7:0]  e;
    if (x == 0) return 32'h0;
    mag = (x < 0) ? -x : x;
    p = 0;
    for (int i = 0; i < 24; i++) if (mag >= (1 << i)) p = i;
    e    = 8'(127 + p);
    frac = 32'(mag << (23 - p)) & 32'h007F_FFFF;
    return {(x < 0), e, frac[22:0]};
  endfunction

  function automatic logic [31:0] modelAdd(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return QNAN;
    return intToFp32(fp32ToInt(a) + fp32ToInt(b));
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: event not expected at cycle %0d", name, cycleCount);
  endtask

  // Behavioural adder: answers each exec with z after adderLatency cycles,
  // or never when muted. A requested late done pulses regardless of state.
  always @(negedge clk) begin
    static int pendingCnt = 0;
    static int lateSeen = 0;
    static logic [31:0] pendingZ = '0;
    adderDone = 1'b0;
    if (pendingCnt > 0) begin
      pendingCnt = pendingCnt - 1;
      if (pendingCnt == 0) begin
        adderDone = 1'b1;
        adderZ    = pendingZ;
      end
    end
    if (lateSeen != lateDoneCount) begin
      lateSeen  = lateDoneCount;
      adderDone = 1'b1;
      adderZ    = 32'h1234_5678;
    end
    if (adder_exec_o && !adderMute) begin
      pendingZ   = modelAdd(adder_a_o, adder_b_o);
      pendingCnt = adderLatency;
    end
  end

  // Monitor: pops an expectation on each grant and checks the exec and the
  // response of that transaction against it.
  always @(negedge clk) begin
    static bit   active = 0;
    static bit   rspPrev = 0;
    static int   execCount = 0;
    static int   execCycle = 0;
    static int   resetSeen = 0;
    static txn_t cur = '{0, '0, '0, '0, 1'b0, 0};
    if (resetSeen != resetCount) begin
      resetSeen = resetCount;
      active    = 0;
      rspPrev   = 0;
      expQ.delete();
    end
    if (rspPrev) begin
      checkOutput("busy_after_rsp", 32'(busy_o), 32'd0);
      rspPrev = 0;
    end
    if (|req_ready_o) begin
      if (active || expQ.size() == 0) begin
        failNow("unexpected_grant");
      end else begin
        cur       = expQ.pop_front();
        active    = 1;
        execCount = 0;
        checkOutput("grant", 32'(req_ready_o), 32'(1 << cur.idx));
        checkOutput("busy_at_grant", 32'(busy_o), 32'd1);
      end
    end
    if (adder_exec_o) begin
      if (!active) begin
        failNow("stray_exec");
      end else begin
        execCount++;
        if (execCount == 1) begin
          execCycle  = cycleCount;
          lastAdderB = adder_b_o;
          checkOutput("adder_a", adder_a_o, cur.a);
          checkOutput("adder_b", adder_b_o, cur.b);
        end
      end
    end
    if (|rsp_valid_o) begin
      if (!active) begin
        failNow("unexpected_rsp");
      end else begin
        lastRspValue = rsp_value_o;
        lastRspMask  = rsp_valid_o;
        lastRspErr   = rsp_err_o;
        lastLatency  = cycleCount - execCycle;
        checkOutput("rsp_mask", 32'(rsp_valid_o), 32'(1 << cur.idx));
        checkOutput("rsp_value", rsp_value_o, cur.value);
        checkOutput("rsp_err", 32'(rsp_err_o), 32'(cur.err));
        checkOutput("exec_count", 32'(execCount), 32'd1);
        checkOutput("latency", 32'(lastLatency), 32'(cur.lat + 1));
        checkOutput("a_stable", adder_a_o, cur.a);
        checkOutput("b_stable", adder_b_o, cur.b);
        checkOutput("busy_at_rsp", 32'(busy_o), 32'd1);
        active  = 0;
        rspPrev = 1;
        rspCount++;
      end
    end
  end

  // One negedge step; granted requesters drop and scramble their operands
  // to prove the arbiter latched them.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reqValid[i] && req_ready_o[i]) begin
        reqValid[i] = 1'b0;
        reqA[i]     = $urandom;
        reqB[i]     = $urandom;
        reqSub[i]   = 1'($urandom);
        anyReady    = 1;
      end
    end
  endtask

  // Raise a set of requests together, predict their service order from the
  // round-robin pointer, then wait for every predicted response. An optional
  // requester withdraws right after the first grant of the round.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input int withdrawIdx,
                               input int lat, input bit mute, input bit directed);
    int   order[$];
    int   n;
    int   target;
    int   budget;
    int   wd;
    txn_t t;
    order = {};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (mask[(modelPtr + k) % NUM_REQ]) order.push_back((modelPtr + k) % NUM_REQ);
    end
    wd = withdrawIdx;
    if (wd >= 0 && (order.size() < 2 || order[0] == wd || !mask[wd])) wd = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[i]) begin
        reqValid[i] = 1'b1;
        if (directed) begin
          reqA[i] = dirA[i]; reqB[i] = dirB[i]; reqSub[i] = dirSub[i];
        end else begin
          reqA[i]   = intToFp32(int'($urandom_range(0, 400)) - 200);
          reqB[i]   = intToFp32(int'($urandom_range(0, 400)) - 200);
          reqSub[i] = 1'($urandom);
        end
      end
    end
    n = 0;
    foreach (order[k]) begin
      if (order[k] != wd) begin
        t.idx   = order[k];
        t.a     = reqA[order[k]];
        t.b     = {reqB[order[k]][31] ^ reqSub[order[k]], reqB[order[k]][30:0]};
        t.value = mute ? QNAN : modelAdd(t.a, t.b);
        t.err   = mute;
        t.lat   = mute ? TIMEOUT : lat;
        expQ.push_back(t);
        modelPtr = (order[k] + 1) % NUM_REQ;
        n++;
      end
    end
    adderLatency = lat;
    adderMute    = mute;
    anyReady     = 0;
    target       = rspCount + n;
    budget       = n * (TIMEOUT + 10) + 20;
    while (rspCount < target && budget > 0) begin
      tick();
      budget--;
      if (wd >= 0 && anyReady && reqValid[wd]) reqValid[wd] = 1'b0;
    end
    if (budget == 0) failNow("round_timeout");
    checkOutput("requests_drained", 32'(reqValid), 32'd0);
  endtask

  initial begin
    int budget;
    int sawRsp;
    reset_ni  = 1'b0;
    reqValid  = '0;
    reqSub    = '0;
    reqA      = '0;
    reqB      = '0;
    adderDone = 1'b0;
    adderZ    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dirA[i] = '0; dirB[i] = '0; dirSub[i] = 1'b0;
    end
    repeat (3) tick();
    $display("[TB] checking reset state");
    checkOutput("rst_ready", 32'(req_ready_o), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_exec", 32'(adder_exec_o), 32'd0);
    checkOutput("rst_adder_a", adder_a_o, 32'd0);
    checkOutput("rst_adder_b", adder_b_o, 32'd0);
    checkOutput("rst_value", rsp_value_o, 32'd0);
    checkOutput("rst_adder_reset", 32'(adder_reset_o), 32'd1);
    reset_ni = 1'b1;
    tick();
    checkOutput("adder_reset_released", 32'(adder_reset_o), 32'd0);

    $display("[TB] all four requesters, eight transactions");
    applyStimulus(4'b1111, -1, 2, 0, 0);
    applyStimulus(4'b1111, -1, 3, 0, 0);

    $display("[TB] directed 1.0 + 2.0 from requester 0");
    dirA[0] = 32'h3F80_0000; dirB[0] = 32'h4000_0000; dirSub[0] = 1'b0;
    applyStimulus(4'b0001, -1, 3, 0, 1);
    checkOutput("t1_value", lastRspValue, 32'h4040_0000);
    checkOutput("t1_mask", 32'(lastRspMask), 32'h1);
    checkOutput("t1_err", 32'(lastRspErr), 32'd0);

    $display("[TB] directed 3.0 - 1.0 from requester 2");
    dirA[2] = 32'h4040_0000; dirB[2] = 32'h3F80_0000; dirSub[2] = 1'b1;
    applyStimulus(4'b0100, -1, 4, 0, 1);
    checkOutput("t2_adder_b", lastAdderB, 32'hBF80_0000);
    checkOutput("t2_value", lastRspValue, 32'h4000_0000);
    checkOutput("t2_mask", 32'(lastRspMask), 32'h4);

    $display("[TB] NaN operand passes through");
    dirA[1] = 32'h7FC0_0000; dirB[1] = 32'h3F80_0000; dirSub[1] = 1'b0;
    applyStimulus(4'b0010, -1, 1, 0, 1);
    checkOutput("t4_value", lastRspValue, 32'hFFC0_0000);
    checkOutput("t4_err", 32'(lastRspErr), 32'd0);

    $display("[TB] randomized rounds with withdrawals");
    for (int r = 0; r < 12; r++) begin
      applyStimulus(NUM_REQ'($urandom_range(1, 15)), int'($urandom_range(0, NUM_REQ - 1)),
                    int'($urandom_range(1, 6)), 0, 0);
    end

    // The response arrives TIMEOUT cycles after the exec pulse ends.
    $display("[TB] watchdog with a silent adder");
    applyStimulus(4'b1000, -1, 1, 1, 0);
    checkOutput("t5_value", lastRspValue, QNAN);
    checkOutput("t5_err", 32'(lastRspErr), 32'd1);
    checkOutput("t5_latency", 32'(lastLatency), 32'(TIMEOUT + 1));
    lateDoneCount++;
    sawRsp = 0;
    repeat (6) begin
      tick();
      sawRsp = sawRsp | int'(|rsp_valid_o) | int'(busy_o);
    end
    checkOutput("t5_late_done_ignored", 32'(sawRsp), 32'd0);

    $display("[TB] reset during WAIT");
    adderMute   = 1;
    reqValid[1] = 1'b1;
    reqA[1]     = intToFp32(5);
    reqB[1]     = intToFp32(7);
    reqSub[1]   = 1'b0;
    expQ.push_back('{1, intToFp32(5), intToFp32(7), QNAN, 1'b1, TIMEOUT});
    anyReady = 0;
    budget   = 20;
    while (!anyReady && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) failNow("t6_grant_timeout");
    repeat (10) tick();
    reset_ni = 1'b0;
    resetCount++;
    #1;
    checkOutput("t6_adder_reset", 32'(adder_reset_o), 32'd1);
    tick();
    checkOutput("t6_busy_cleared", 32'(busy_o), 32'd0);
    checkOutput("t6_adder_a_cleared", adder_a_o, 32'd0);
    checkOutput("t6_value_cleared", rsp_value_o, 32'd0);
    reset_ni  = 1'b1;
    modelPtr  = 0;
    adderMute = 0;
    sawRsp    = 0;
    repeat (TIMEOUT + 8) begin
      tick();
      sawRsp = sawRsp | int'(|rsp_valid_o);
    end
    checkOutput("t6_no_rsp", 32'(sawRsp), 32'd0);
    applyStimulus(4'b1010, -1, 2, 0, 0);
    checkOutput("t6_req3_served_last", 32'(lastRspMask), 32'h8);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
